// File: rtl/formula_chain_pkg.sv
// Shared types and default sizing for the chained square-root sequencer.
// The state type is kept here so benches and wrappers can decode it.
package formula_chain_pkg;

    localparam int DEF_N_ARGS = 3;
    localparam int DEF_W      = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/formula_chain_fsm.sv
// Evaluates isqrt(args[0] + isqrt(args[1] + ... + isqrt(args[N_ARGS-1])))
// by sequencing one shared external isqrt unit, innermost argument first.
module formula_chain_fsm
    import formula_chain_pkg::*;
#(
    parameter int N_ARGS = DEF_N_ARGS,
    parameter int W      = DEF_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arg_vld,
    output logic                arg_rdy,
    input  logic [N_ARGS*W-1:0] args,
    output logic                res_vld,
    input  logic                res_rdy,
    output logic [W-1:0]        res,
    output logic                isqrt_x_vld,
    output logic [W-1:0]        isqrt_x,
    input  logic                isqrt_y_vld,
    input  logic [W/2-1:0]      isqrt_y
);

    localparam int H     = W / 2;
    localparam int IDX_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ARGS - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [H-1:0]          acc;
    logic [H-1:0]          res_q;
    logic                  res_vld_q;
    logic [N_ARGS*W-1:0]   args_q;
    logic [W-1:0]          operand;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            acc       <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arg_vld) begin
                        idx   <= IDX_LAST;
                        acc   <= '0;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Responses arriving in any other state are simply dropped.
                    if (isqrt_y_vld) begin
                        acc <= isqrt_y;
                        if (idx == '0) begin
                            res_q     <= isqrt_y;
                            res_vld_q <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    if (res_rdy) begin
                        res_vld_q <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the argument store is pure datapath, written before it is ever
    // read, so it carries no reset and stays out of the reset tree.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && arg_vld) begin
            args_q <= args;
        end
    end

    // NOTE: combinational logic assigns every output on every path, so no
    // latch can be inferred.
    always_comb begin
        operand = args_q[int'(idx) * W +: W] + {{(W - H){1'b0}}, acc};
    end

    assign arg_rdy     = (state == ST_IDLE);
    assign isqrt_x_vld = (state == ST_ISSUE);
    assign isqrt_x     = isqrt_x_vld ? operand : '0;
    assign res_vld     = res_vld_q;
    assign res         = {{(W - H){1'b0}}, res_q};

endmodule

// File: tb/tb_formula_chain_fsm.sv
// Randomized bench for formula_chain_fsm: a 3-stage and a 1-stage instance,
// each served by a latency-programmable isqrt responder and a reference model.
module tb_formula_chain_fsm;

    localparam int W  = 32;
    localparam int H  = W / 2;
    localparam int NA = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // 3-stage instance
    logic            a_arg_vld, a_arg_rdy, a_res_vld, a_res_rdy;
    logic [NA*W-1:0] a_args;
    logic [W-1:0]    a_res, a_x;
    logic            a_x_vld, a_y_vld;
    logic [H-1:0]    a_y;

    // 1-stage instance
    logic            b_arg_vld, b_arg_rdy, b_res_vld, b_res_rdy;
    logic [W-1:0]    b_args;
    logic [W-1:0]    b_res, b_x;
    logic            b_x_vld, b_y_vld;
    logic [H-1:0]    b_y;

    formula_chain_fsm #(.N_ARGS(NA), .W(W)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(a_arg_vld), .arg_rdy(a_arg_rdy), .args(a_args),
        .res_vld(a_res_vld), .res_rdy(a_res_rdy), .res(a_res),
        .isqrt_x_vld(a_x_vld), .isqrt_x(a_x),
        .isqrt_y_vld(a_y_vld), .isqrt_y(a_y)
    );

    formula_chain_fsm #(.N_ARGS(1), .W(W)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(b_arg_vld), .arg_rdy(b_arg_rdy), .args(b_args),
        .res_vld(b_res_vld), .res_rdy(b_res_rdy), .res(b_res),
        .isqrt_x_vld(b_x_vld), .isqrt_x(b_x),
        .isqrt_y_vld(b_y_vld), .isqrt_y(b_y)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Floor square root by building the root one bit at a time.
    function automatic logic [H-1:0] isqrt_ref(input logic [W-1:0] x);
        logic [63:0] r, t;
        r = 0;
        for (int b = H - 1; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= {32'd0, x}) r = t;
        end
        return r[H-1:0];
    endfunction

    // isqrt responders: answer L cycles after a request, optionally inject a stray response.
    int           a_lat = 1, a_cnt = 0, b_lat = 1, b_cnt = 0;
    logic         a_spur = 1'b0;
    logic [W-1:0] a_hold, b_hold;
    logic [W-1:0] a_xs[$];
    logic [W-1:0] b_xs[$];

    initial begin
        a_y_vld = 1'b0;
        a_y = '0;
        forever begin
            @(negedge clk);
            a_y_vld = 1'b0;
            if (a_cnt > 0) begin
                a_cnt--;
                if (a_cnt == 0) begin
                    a_y_vld = 1'b1;
                    a_y = isqrt_ref(a_hold);
                end
            end else if (a_spur) begin
                a_spur = 1'b0;
                a_y_vld = 1'b1;
                a_y = H'($urandom);
            end
            if (a_x_vld) begin
                a_xs.push_back(a_x);
                a_hold = a_x;
                a_cnt = a_lat;
            end else begin
                check("a_x_idle_zero", a_x, 0);
            end
        end
    end

    initial begin
        b_y_vld = 1'b0;
        b_y = '0;
        forever begin
            @(negedge clk);
            b_y_vld = 1'b0;
            if (b_cnt > 0) begin
                b_cnt--;
                if (b_cnt == 0) begin
                    b_y_vld = 1'b1;
                    b_y = isqrt_ref(b_hold);
                end
            end
            if (b_x_vld) begin
                b_xs.push_back(b_x);
                b_hold = b_x;
                b_cnt = b_lat;
            end
        end
    end

    task automatic run_a(input logic [NA*W-1:0] av, input int lat, input int hold);
        logic [W-1:0] exp_x[$];
        logic [H-1:0] acc;
        logic [W-1:0] x;
        int t0, n;
        acc = '0;
        for (int k = NA - 1; k >= 0; k--) begin
            x = av[k*W +: W] + W'(acc);
            exp_x.push_back(x);
            acc = isqrt_ref(x);
        end
        a_lat = lat;
        a_xs.delete();
        @(negedge clk);
        a_args = av;
        a_arg_vld = 1'b1;
        n = 0;
        while (!a_arg_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_accept_timeout", (n < 200), 1);
        t0 = cyc;
        @(negedge clk);
        a_arg_vld = 1'b0;
        a_args = {$urandom, $urandom, $urandom};
        check("a_rdy_busy", a_arg_rdy, 0);
        n = 0;
        while (!a_res_vld && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("a_latency", cyc - t0, NA * (lat + 1) + 1);
        check("a_res", a_res, W'(acc));
        check("a_nreq", a_xs.size(), NA);
        for (int i = 0; i < NA && i < a_xs.size(); i++) check("a_x_seq", a_xs[i], exp_x[i]);
        for (int i = 0; i < hold; i++) begin
            a_arg_vld = 1'b1;
            a_args = {$urandom, $urandom, $urandom};
            if (i == 1) a_spur = 1'b1;
            @(negedge clk);
            check("a_hold_vld", a_res_vld, 1);
            check("a_hold_res", a_res, W'(acc));
            check("a_hold_rdy", a_arg_rdy, 0);
        end
        a_res_rdy = 1'b1;
        @(negedge clk);
        a_res_rdy = 1'b0;
        check("a_first_idle_rdy", a_arg_rdy, 1);
        check("a_vld_drop", a_res_vld, 0);
        a_arg_vld = 1'b0;
    endtask

    task automatic run_b(input logic [W-1:0] av, input int lat);
        int t0, n;
        b_lat = lat;
        b_xs.delete();
        @(negedge clk);
        b_args = av;
        b_arg_vld = 1'b1;
        n = 0;
        while (!b_arg_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("b_accept_timeout", (n < 200), 1);
        t0 = cyc;
        @(negedge clk);
        b_arg_vld = 1'b0;
        b_args = $urandom;
        n = 0;
        while (!b_res_vld && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("b_latency", cyc - t0, lat + 2);
        check("b_res", b_res, W'(isqrt_ref(av)));
        check("b_nreq", b_xs.size(), 1);
        if (b_xs.size() > 0) check("b_x", b_xs[0], av);
        b_res_rdy = 1'b1;
        @(negedge clk);
        b_res_rdy = 1'b0;
        check("b_idle_rdy", b_arg_rdy, 1);
    endtask

    task automatic reset_mid_run();
        int n;
        a_lat = 3;
        a_xs.delete();
        @(negedge clk);
        a_args = {32'd400, 32'd77, 32'd5};
        a_arg_vld = 1'b1;
        n = 0;
        while (!a_arg_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        a_arg_vld = 1'b0;
        n = 0;
        while (a_xs.size() < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_second_req_timeout", (n < 200), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_arg_rdy", a_arg_rdy, 1);
        check("rst_res_vld", a_res_vld, 0);
        check("rst_x_vld", a_x_vld, 0);
        check("rst_res", a_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_clk_rdy", a_arg_rdy, 1);
        // The responder's pending answer lands now, after the abort.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_result", a_res_vld, 0);
            check("rst_stay_idle", a_arg_rdy, 1);
        end
    endtask

    initial begin
        a_arg_vld = 1'b0; a_res_rdy = 1'b0; a_args = '0;
        b_arg_vld = 1'b0; b_res_rdy = 1'b0; b_args = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_arg_rdy", a_arg_rdy, 1);
        check("reset_res_vld", a_res_vld, 0);
        check("reset_x_vld", a_x_vld, 0);
        check("reset_res", a_res, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_rdy", a_arg_rdy, 1);

        run_a({32'd16, 32'd5, 32'd13}, 1, 5);
        run_a({32'd0, 32'hFFFF_FFFF, 32'd1}, 2, 1);
        run_a({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 1, 2);
        reset_mid_run();
        run_a({32'd9, 32'd1000, 32'd12345}, 4, 0);
        for (int i = 0; i < 6; i++) begin
            run_a({$urandom, $urandom, $urandom}, $urandom_range(1, 4), $urandom_range(0, 3));
        end

        run_b(32'd81, 2);
        for (int i = 0; i < 3; i++) begin
            run_b($urandom, $urandom_range(1, 4));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/formula_chain_fsm.md
FORMULA_CHAIN_FSM -- requirements
Module: formula_chain_fsm

Interface
REQ-001 SHALL have parameter N_ARGS, default 3, number of chained square-root stages (legal range 1..16).
REQ-002 SHALL have parameter W, default 32, argument width (even, 4..64).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port arg_vld, input, 1, argument set valid.
REQ-006 SHALL have port arg_rdy, output, 1, block can accept an argument set.
REQ-007 SHALL have port args, input, N_ARGS*W, packed arguments; args[k] occupies bits [k*W +: W].
REQ-008 SHALL have port res_vld, output, 1, result valid.
REQ-009 SHALL have port res_rdy, input, 1, consumer accepts result.
REQ-010 SHALL have port res, output, W, result zero-extended from W/2 bits.
REQ-011 SHALL have port isqrt_x_vld, output, 1, request to external isqrt.
REQ-012 SHALL have port isqrt_x, output, W, isqrt operand.
REQ-013 SHALL have port isqrt_y_vld, input, 1, isqrt response valid.
REQ-014 SHALL have port isqrt_y, input, W/2, isqrt response.

Function
REQ-015 SHALL compute res = isqrt(args[0] + isqrt(args[1] + ... + isqrt(args[N_ARGS-1]))), using one external isqrt only.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-017 IDLE: arg_rdy=1; on arg_vld, register all args, set idx=N_ARGS-1, set acc=0, go to ISSUE; arg_rdy SHALL be 0 in every other state.
REQ-018 ISSUE: isqrt_x_vld=1 for exactly one cycle, isqrt_x = args_q[idx] + acc, then go to WAIT.
REQ-019 WAIT: on isqrt_y_vld, acc<=isqrt_y; if idx==0, res<=isqrt_y and go to DONE; otherwise idx<=idx-1 and go to ISSUE.
REQ-020 DONE: res_vld=1, res held stable; on res_rdy go to IDLE; res_vld SHALL be a registered Moore output.
REQ-021 Additions SHALL wrap modulo 2^W; no saturation or overflow flag.
REQ-022 isqrt_y_vld outside WAIT SHALL be ignored, with no state or data change.
REQ-023 With isqrt latency L (y_vld L>=1 cycles after x_vld), arg accepted at cycle T, res_vld SHALL rise at T + N_ARGS*(L+1) + 1.
REQ-024 Arguments SHALL be sampled only at acceptance; later changes on args SHALL NOT affect the result.
REQ-025 arg_vld while busy SHALL NOT be consumed; the new set SHALL be accepted in the first IDLE cycle.
REQ-026 isqrt_x SHALL be 0 when isqrt_x_vld=0.

Reset
REQ-027 On rst_n low, the block SHALL immediately enter IDLE with res_vld=0, res=0, isqrt_x_vld=0, idx=0, acc=0, including mid-operation (computation aborted, no result).
REQ-028 After reset deassertion, arg_rdy SHALL be 1 on the first clock.

Structure
REQ-029 Package formula_chain_pkg SHALL hold the state enum type and default N_ARGS/W constants.
REQ-030 isqrt SHALL remain external; no sub-module is required; idx width SHALL be $clog2(N_ARGS) (min 1).

Verification
REQ-031 N_ARGS=3, W=32, args={13,5,16} (args[0]=13), L=1 -> isqrt_x sequence 16, 9, 16; res=4; res_vld at T+7.
REQ-032 args[2]=0, args[1]=32'hFFFF_FFFF, args[0]=1 -> isqrt_x 0, 0xFFFFFFFF, 0x00010000 (wrap-free); res=256.
REQ-033 res_rdy held low 5 cycles in DONE -> res_vld and res stable, arg_rdy=0; arg_vld ignored until IDLE.
REQ-034 N_ARGS=1, args=81 -> single isqrt request, res=9, res_vld at T+L+2.
REQ-035 rst_n low during second WAIT, then spurious isqrt_y_vld -> IDLE, res_vld stays 0, next argument set computes correctly.
